// File: rtl/serial_tl_host_pkg.sv
// Shared types for the serial TileLink host bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_tl_host_pkg;

   // One state per outgoing TSI beat, plus the wait/ack states
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CMD     = 4'd1,
      ADDR_LO = 4'd2,
      ADDR_HI = 4'd3,
      LEN_LO  = 4'd4,
      LEN_HI  = 4'd5,
      WDATA   = 4'd6,
      RWAIT   = 4'd7,
      ACK     = 4'd8
   } state_e;

   localparam logic TSI_CMD_READ  = 1'b0;
   localparam logic TSI_CMD_WRITE = 1'b1;

endpackage

// File: rtl/serial_tl_host_bridge.sv
// Host end of the serial TileLink (TSI) port: one WB single-word access -> one TSI frame.
// Latency: write ack rises on the 8th edge after request; read = 5 beats + response + ACK.
// Backpressure: beat bits held while tl_in_valid_o & !tl_in_ready_i; ready toward chip only in RWAIT.
//
// Ports:
//   wb_clk_i / wb_rst_ni          clock, async active-low reset
//   wbs_*                         Wishbone slave (single-word accesses)
//   addr_hi_i                     upper TSI address word, sampled at request accept
//   tl_in_*                       request beats toward the chip
//   tl_out_*                      response beats from the chip
//   busy_o, err_o, err_clr_i      status: not idle, sticky error, error clear
module serial_tl_host_bridge
   import serial_tl_host_pkg::*;
#(
   parameter int unsigned W        = 32,
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   input  logic [31:0]   addr_hi_i,
   output logic          tl_in_valid_o,
   input  logic          tl_in_ready_i,
   output logic [W-1:0]  tl_in_bits_o,
   input  logic          tl_out_valid_i,
   output logic          tl_out_ready_o,
   input  logic [W-1:0]  tl_out_bits_i,
   output logic          busy_o,
   output logic          err_o,
   input  logic          err_clr_i
);

   localparam int unsigned    CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Leaving RWAIT on the edge where the counter would reach TIMEOUT-1
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

   state_e           state_q;
   logic             we_q;
   logic [W-1:0]     adr_q;
   logic [W-1:0]     wdat_q;
   logic [W-1:0]     addr_hi_q;
   logic [31:0]      rdata_q;
   logic             ack_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             req;
   logic             beat;
   logic             rsp_beat;
   logic             sel_err;
   logic             tmo;
   logic             err_d;

   // The !ack term stops the still-asserted request of the cycle just acked
   // from being taken a second time.
   assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign beat     = tl_in_valid_o & tl_in_ready_i;
   assign rsp_beat = tl_out_valid_i & tl_out_ready_o;
   assign sel_err  = (state_q == IDLE) && req && wbs_we_i && (wbs_sel_i != 4'hF);
   assign tmo      = (state_q == RWAIT) && !tl_out_valid_i && (cnt_q == CNT_LAST);
   // A new error in the same cycle as a clear request wins
   assign err_d    = sel_err | tmo | (err_q & ~err_clr_i);

   // Beat mux: bits come only from registered state, so they hold until the beat
   always_comb begin
      tl_in_valid_o = 1'b0;
      tl_in_bits_o  = '0;
      case (state_q)
         CMD: begin
            tl_in_valid_o = 1'b1;
            tl_in_bits_o  = we_q ? W'(TSI_CMD_WRITE) : W'(TSI_CMD_READ);
         end
         ADDR_LO: begin
            tl_in_valid_o = 1'b1;
            tl_in_bits_o  = adr_q;
         end
         ADDR_HI: begin
            tl_in_valid_o = 1'b1;
            tl_in_bits_o  = addr_hi_q;
         end
         LEN_LO, LEN_HI: begin
            tl_in_valid_o = 1'b1;
            tl_in_bits_o  = '0;
         end
         WDATA: begin
            tl_in_valid_o = 1'b1;
            tl_in_bits_o  = wdat_q;
         end
         default: begin
            tl_in_valid_o = 1'b0;
            tl_in_bits_o  = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdat_q    <= '0;
         addr_hi_q <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= err_d;
         case (state_q)
            IDLE: begin
               if (req) begin
                  we_q      <= wbs_we_i;
                  adr_q     <= wbs_adr_i;
                  wdat_q    <= wbs_dat_i;
                  addr_hi_q <= addr_hi_i;
                  // Partial writes cannot be framed as one word: complete with error
                  state_q   <= sel_err ? ACK : CMD;
               end
            end
            CMD:     if (beat) state_q <= ADDR_LO;
            ADDR_LO: if (beat) state_q <= ADDR_HI;
            ADDR_HI: if (beat) state_q <= LEN_LO;
            LEN_LO:  if (beat) state_q <= LEN_HI;
            LEN_HI:  if (beat) state_q <= we_q ? WDATA : RWAIT;
            WDATA:   if (beat) state_q <= ACK;
            RWAIT: begin
               if (rsp_beat) begin
                  rdata_q <= tl_out_bits_i;
                  cnt_q   <= '0;
                  state_q <= ACK;
               end else if (tmo) begin
                  rdata_q <= ERR_DATA;
                  cnt_q   <= '0;
                  state_q <= ACK;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            ACK: begin
               // Master may have abandoned the cycle mid-frame; then stay silent
               ack_q   <= wbs_cyc_i;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wbs_ack_o      = ack_q;
   assign wbs_dat_o      = rdata_q;
   assign tl_out_ready_o = (state_q == RWAIT);
   assign busy_o         = (state_q != IDLE);
   assign err_o          = err_q;

endmodule
